lin_node_ctrl: RTL
==================

# lin_node_ctrl

Parametrised power-mode controller for a LIN slave node, sitting between the LIN protocol engine (header decoder, bus activity detector) and the slave frame-processing logic. It sequences INIT → OPERATION → SLEEP, enters sleep on a go-to-sleep command or on bus inactivity, and leaves sleep on a bus wake-up or received header. It also supports node-originated wake-up: a timed dominant wake pulse with bounded retries.

## Interface
- `INIT_CYCLES`, default 30: cycles spent in INIT before OPERATION (≥1).
- `IDLE_TIMEOUT`, default 100: consecutive inactive cycles in OPERATION before SLEEP (≥2).
- `WAKE_PULSE_CYCLES`, default 8: width of `wake_tx` dominant pulse (≥1).
- `WAKE_WAIT_CYCLES`, default 50: wait for master response after each wake pulse (≥1).
- `WAKE_RETRIES`, default 2: extra pulses after the first before giving up (0..15).
- `CNT_W`, default 16: width of the shared timer. Must hold max(all cycle parameters).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `hdr_valid` in 1: one-cycle strobe, header received.
- `hdr_pid` in 8: protected ID of that header. Informational; only `hdr_valid` affects the FSM.
- `sleep_cmd` in 1: go-to-sleep command decoded (level or strobe).
- `bus_active` in 1: bus edge seen this cycle.
- `bus_wake_det` in 1: valid wake-up pulse detected on bus.
- `local_wake_req` in 1: application requests node-originated wake.
- `init_start` out 1: high while in INIT.
- `init_finish` out 1: one-cycle pulse on INIT→OPERATION.
- `en_slv_operation` out 1: high only in OPERATION.
- `s_read_from_mem` out 1: high only in OPERATION.
- `wake_tx` out 1: drive bus dominant; high only in WAKE_TX.
- `master_req` out 1: one-cycle pulse when leaving SLEEP/WAKE_WAIT toward INIT.
- `wake_fail` out 1: one-cycle pulse when retries are exhausted.
- `state` out 3: current state encoding.

## Operation
- States and encoding: INIT=0, OPERATION=1, SLEEP=2, WAKE_TX=3, WAKE_WAIT=4. Any other value goes to INIT.
- Timer: a single `CNT_W`-bit counter, cleared on every state change; otherwise +1 per cycle. It saturates and never wraps.
- INIT: when timer == `INIT_CYCLES`-1, go to OPERATION and pulse `init_finish`.
- OPERATION: the idle timer clears on any cycle with `bus_active` or `hdr_valid`. Exit priority:
  1. `sleep_cmd` → SLEEP.
  2. Idle timer == `IDLE_TIMEOUT`-1 with no activity that cycle → SLEEP.
- SLEEP: exit priority:
  1. `bus_wake_det` or `hdr_valid` → INIT, with a `master_req` pulse.
  2. `local_wake_req` → WAKE_TX, with the retry counter cleared.
- WAKE_TX: when timer == `WAKE_PULSE_CYCLES`-1 → WAKE_WAIT.
- WAKE_WAIT exits:
  - `hdr_valid` or `bus_active` → INIT, with a `master_req` pulse.
  - On timer == `WAKE_WAIT_CYCLES`-1 with no response:
    - if retry < `WAKE_RETRIES`: retry+1 → WAKE_TX;
    - otherwise pulse `wake_fail` → SLEEP.
- `sleep_cmd` is ignored outside OPERATION.
- Simultaneous events:
  - `sleep_cmd` with activity in OPERATION → SLEEP.
  - Response arriving on the timeout cycle of WAKE_WAIT → INIT; no retry.

## Timing
- All outputs are registered, decoded from the next state, so each output is valid in the first cycle the FSM occupies the corresponding state.
- Reset values: `state`=INIT; all outputs 0 (including `init_start`). Timer and retry counter are 0.
- After `reset` deasserts:
  - `init_start` rises at the first clock edge.
  - INIT lasts exactly `INIT_CYCLES` cycles.
- Pulse widths and durations:
  - `wake_tx` is high for exactly `WAKE_PULSE_CYCLES` cycles per attempt.
  - WAKE_WAIT lasts at most `WAKE_WAIT_CYCLES` cycles.
- Input-to-state latency: one cycle from input sample to the new state/outputs.
- Reset asserted mid-operation (any state, including during `wake_tx`): outputs drop to 0 immediately (async), and the FSM restarts in INIT.

## Configuration
- `LIN_LOCAL_WAKE_EN` defined: WAKE_TX/WAKE_WAIT, retry counter, `wake_tx` and `wake_fail` logic are present as described.
- Not defined:
  - `local_wake_req` is ignored.
  - `wake_tx` and `wake_fail` are tied to 0.
  - SLEEP exits only on `bus_wake_det`/`hdr_valid`.
  - State codes 3/4 are unreachable and fall back to INIT.

## Test plan
- Reset release, defaults: `init_start`=1 for 30 cycles; `init_finish` pulses once; `en_slv_operation`=`s_read_from_mem`=1 from cycle 31.
- OPERATION with no `bus_active` for 100 cycles → SLEEP on cycle 100, `en_slv_operation`=0. A `bus_active` at cycle 60 defers SLEEP to 100 cycles after it.
- `sleep_cmd` and `bus_active` asserted together in OPERATION → SLEEP next cycle. Then `bus_wake_det` → `master_req` pulse, INIT, full 30-cycle init.
- SLEEP + `local_wake_req`, no response → three 8-cycle `wake_tx` pulses, each followed by 50-cycle waits, then a `wake_fail` pulse and SLEEP.
- SLEEP + `local_wake_req`, `hdr_valid` at wait cycle 10 of the first attempt → `master_req` pulse, INIT, no further `wake_tx`.
- `reset` asserted during `wake_tx` → `wake_tx`=0 immediately. After release: INIT, retry counter 0.

Source files
------------

// File: rtl/lin_node_ctrl.sv
// lin_node_ctrl: power-mode controller for a LIN slave node.
// Sequences INIT -> OPERATION -> SLEEP and wakes on bus wake-up or header.
// Define LIN_LOCAL_WAKE_EN to add node-originated wake-up (WAKE_TX/WAKE_WAIT
// with bounded retries); without it local_wake_req is ignored and
// wake_tx/wake_fail are tied low.
module lin_node_ctrl #(
  parameter int INIT_CYCLES       = 30,
  parameter int IDLE_TIMEOUT      = 100,
  parameter int WAKE_PULSE_CYCLES = 8,
  parameter int WAKE_WAIT_CYCLES  = 50,
  parameter int WAKE_RETRIES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hdr_valid,
  input  logic [7:0] hdr_pid,
  input  logic       sleep_cmd,
  input  logic       bus_active,
  input  logic       bus_wake_det,
  input  logic       local_wake_req,
  output logic       init_start,
  output logic       init_finish,
  output logic       en_slv_operation,
  output logic       s_read_from_mem,
  output logic       wake_tx,
  output logic       master_req,
  output logic       wake_fail,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_OPER  = 3'd1,
    ST_SLEEP = 3'd2,
    ST_WTX   = 3'd3,
    ST_WWAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_PULSE_LAST = CNT_W'(WAKE_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_WAIT_LAST  = CNT_W'(WAKE_WAIT_CYCLES - 1);
  localparam logic [3:0]       LP_RETRIES    = 4'(WAKE_RETRIES);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic             r_run;       // low until the first edge after reset release
  logic             w_activity;
  logic             w_state_chg;
  logic             w_mreq;
  logic             w_finish;
  logic             w_fail;
  logic             w_unused_ok;

`ifdef LIN_LOCAL_WAKE_EN
  logic [3:0] r_retry;
  logic       w_retry_clr;
  logic       w_retry_inc;
  assign w_unused_ok = ^hdr_pid;
`else
  assign w_unused_ok = ^{hdr_pid, local_wake_req, LP_PULSE_LAST, LP_WAIT_LAST, LP_RETRIES};
`endif

  assign w_activity  = bus_active | hdr_valid;
  // The reset-release edge counts as entry into INIT so INIT spans exactly INIT_CYCLES.
  assign w_state_chg = !r_run || (w_next != r_state);
  assign state       = r_state;

  // State register and run flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // Next-state decode and transition pulses
  always_comb begin
    w_next   = r_state;
    w_mreq   = 1'b0;
    w_finish = 1'b0;
    w_fail   = 1'b0;
`ifdef LIN_LOCAL_WAKE_EN
    w_retry_clr = 1'b0;
    w_retry_inc = 1'b0;
`endif
    if (!r_run) begin
      w_next = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_timer == LP_INIT_LAST) begin
            w_next   = ST_OPER;
            w_finish = 1'b1;
          end
        end
        ST_OPER: begin
          if (sleep_cmd) w_next = ST_SLEEP;
          else if (!w_activity && (r_timer == LP_IDLE_LAST)) w_next = ST_SLEEP;
        end
        ST_SLEEP: begin
          if (bus_wake_det || hdr_valid) begin
            w_next = ST_INIT;
            w_mreq = 1'b1;
          end
`ifdef LIN_LOCAL_WAKE_EN
          else if (local_wake_req) begin
            w_next      = ST_WTX;
            w_retry_clr = 1'b1;
          end
`endif
        end
`ifdef LIN_LOCAL_WAKE_EN
        ST_WTX: begin
          if (r_timer == LP_PULSE_LAST) w_next = ST_WWAIT;
        end
        ST_WWAIT: begin
          // A response on the timeout cycle wins over a retry.
          if (hdr_valid || bus_active) begin
            w_next = ST_INIT;
            w_mreq = 1'b1;
          end else if (r_timer == LP_WAIT_LAST) begin
            if (r_retry < LP_RETRIES) begin
              w_next      = ST_WTX;
              w_retry_inc = 1'b1;
            end else begin
              w_next = ST_SLEEP;
              w_fail = 1'b1;
            end
          end
        end
`endif
        default: w_next = ST_INIT;
      endcase
    end
  end

  // Shared timer: restarts on state change and on activity in OPERATION, saturates otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (w_state_chg || ((r_state == ST_OPER) && w_activity)) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + CNT_W'(1);
    end
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_start       <= 1'b0;
      init_finish      <= 1'b0;
      en_slv_operation <= 1'b0;
      s_read_from_mem  <= 1'b0;
      master_req       <= 1'b0;
    end else begin
      init_start       <= (w_next == ST_INIT);
      init_finish      <= w_finish;
      en_slv_operation <= (w_next == ST_OPER);
      s_read_from_mem  <= (w_next == ST_OPER);
      master_req       <= w_mreq;
    end
  end

`ifdef LIN_LOCAL_WAKE_EN
  // Retry counter for node-originated wake attempts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_retry <= '0;
    else if (w_retry_clr) r_retry <= '0;
    else if (w_retry_inc) r_retry <= r_retry + 4'd1;
  end

  // Wake pulse drive and give-up pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wake_tx   <= 1'b0;
      wake_fail <= 1'b0;
    end else begin
      wake_tx   <= (w_next == ST_WTX);
      wake_fail <= w_fail;
    end
  end
`else
  assign wake_tx   = 1'b0;
  assign wake_fail = 1'b0;
`endif

endmodule
